inv_expand_key: RTL and testbench

Iterative AES-128 inverse key schedule for the decryption datapath. It takes the final round key (round 10) and regenerates the round keys in decryption order: 10, 9, …, 1, 0 (round 0 is the cipher key). Keys are produced one round per accepted beat over a valid/ready stream. This replaces storing all 11 keys from the forward expansion. The block sits between the key loader and the inverse-round engine.

---
 rtl/inv_expand_key_if.sv | 22 ++
 rtl/inv_expand_key.sv | 156 +++++++++++++++
 tb/tb_inv_expand_key.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_expand_key_if.sv
// Stream bundle between the key loader / inverse-round engine (master) and the
// inverse AES-128 key schedule (slave).
interface inv_expand_key_if;
  logic         start;
  logic [0:127] key_last;
  logic         key_ready;
  logic [0:127] key_out;
  logic         key_valid;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, key_last, key_ready,
    input  key_out, key_valid, key_idx, busy, done
  );

  modport slave (
    input  start, key_last, key_ready,
    output key_out, key_valid, key_idx, busy, done
  );
endinterface

// File: rtl/inv_expand_key.sv
// Iterative AES-128 inverse key schedule: walks from the round-10 key back to
// the cipher key, one round key per accepted valid/ready beat.

module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] substituted
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    p   = 8'h00;
    acc = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ acc;
      acc = xtime(acc);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv         = gf_inv(value);
    substituted = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module inv_expand_key (
  input logic               clk,
  input logic               rst,
  inv_expand_key_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state;
  state_t       state_next;
  logic [0:127] key_q;
  logic [0:127] key_next;
  logic [3:0]   idx_q;
  logic [3:0]   idx_next;
  logic         done_q;
  logic         done_next;

  logic [7:0]   rc;
  logic [0:31]  w0, w1, w2, w3, w4, w5, w6, w7;
  logic [0:31]  rot_w;
  logic [0:31]  sub_w;
  logic [0:127] step_key;

  // Round constant of the key being undone, indexed by its round number.
  always_comb begin
    rc = 8'h00;
    case (idx_q)
      4'd10:   rc = 8'h36;
      4'd9:    rc = 8'h1b;
      4'd8:    rc = 8'h80;
      4'd7:    rc = 8'h40;
      4'd6:    rc = 8'h20;
      4'd5:    rc = 8'h10;
      4'd4:    rc = 8'h08;
      4'd3:    rc = 8'h04;
      4'd2:    rc = 8'h02;
      4'd1:    rc = 8'h01;
      default: rc = 8'h00;
    endcase
  end

  assign w4 = key_q[0:31];
  assign w5 = key_q[32:63];
  assign w6 = key_q[64:95];
  assign w7 = key_q[96:127];

  assign w3 = w7 ^ w6;
  assign w2 = w6 ^ w5;
  assign w1 = w5 ^ w4;

  // g() runs on the recovered w3, so the forward S-box is the right one here.
  assign rot_w = {w3[8:31], w3[0:7]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .value       (rot_w[8*b +: 8]),
      .substituted (sub_w[8*b +: 8])
    );
  end

  assign w0       = w4 ^ sub_w ^ {rc, 24'h000000};
  assign step_key = {w0, w1, w2, w3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      key_q  <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      key_q  <= key_next;
      idx_q  <= idx_next;
      done_q <= done_next;
    end
  end

  // start is only looked at in IDLE, so a start during a run is simply dropped.
  always_comb begin
    state_next = state;
    key_next   = key_q;
    idx_next   = idx_q;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          key_next   = bus.key_last;
          idx_next   = 4'd10;
        end
      end
      RUN: begin
        if (bus.key_ready) begin
          if (idx_q == 4'd0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            key_next = step_key;
            idx_next = idx_q - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.key_out   = key_q;
  assign bus.key_idx   = idx_q;
  assign bus.key_valid = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_inv_expand_key.sv
// Self-checking bench for inv_expand_key: forward key-expansion model feeds a
// scoreboard of expected beats; a negedge monitor pops and compares them.
module tb_inv_expand_key;
  logic clk;
  logic rst;

  inv_expand_key_if bus ();

  inv_expand_key dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
  } beat_t;

  typedef struct {
    logic [127:0] key_last;
    logic [127:0] cipher;
    logic [127:0] exp9;
    logic [127:0] exp1;
  } vec_t;

  beat_t        sb[$];
  vec_t         vecs[3];
  int           checks      = 0;
  int           passes      = 0;
  int           cyc         = 0;
  int           start_cyc   = 0;
  int           done_pulses = 0;
  bit           full_rate   = 0;
  logic [7:0]   sbox_tbl [0:255];
  logic [127:0] fwd_rk   [0:10];
  logic [127:0] obs_key  [0:15];

  localparam logic [127:0] A1_LAST   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] A1_CIPHER = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Forward S-box built from the generator-3 walk of GF(2^8).
  task automatic buildSbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_tbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_tbl[0] = 8'h63;
  endtask

  task automatic expandForward(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rcon [0:9];
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0)
        t = {sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]], sbox_tbl[t[31:24]]}
            ^ {rcon[i/4 - 1], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) fwd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic applyStimulus(input logic [127:0] kl, input logic [127:0] ck);
    beat_t b;
    expandForward(ck);
    for (int r = 10; r >= 0; r--) begin
      b.idx = 4'(r);
      b.key = fwd_rk[r];
      sb.push_back(b);
    end
    for (int i = 0; i < 16; i++) obs_key[i] = '0;
    bus.start    = 1'b1;
    bus.key_last = kl;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    bus.start = 1'b0;
  endtask

  task automatic runUntilDone(input bit rand_ready, output int done_cyc);
    bit seen;
    seen     = 1'b0;
    done_cyc = -1;
    for (int i = 0; i < 300; i++) begin
      bus.key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen     = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    checkOutput("done_seen", 128'(seen), 128'(1));
    checkOutput("sb_drained", 128'(sb.size()), 128'(0));
  endtask

  // Monitor: consumes handshakes, checks stalls and the done pulse placement.
  initial begin
    bit           done_due;
    bit           prev_stall;
    logic [127:0] prev_key;
    logic [3:0]   prev_idx;
    beat_t        b;
    done_due   = 1'b0;
    prev_stall = 1'b0;
    prev_key   = '0;
    prev_idx   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (bus.done || done_due) checkOutput("done_pulse", 128'(bus.done), 128'(done_due));
        if (bus.done) begin
          done_pulses++;
          checkOutput("done_with_valid", 128'(bus.key_valid), 128'(0));
        end
        done_due = 1'b0;
        if (prev_stall && bus.key_valid) begin
          checkOutput("stall_key", bus.key_out, prev_key);
          checkOutput("stall_idx", 128'(bus.key_idx), 128'(prev_idx));
        end
        prev_stall = 1'b0;
        if (bus.key_valid) begin
          checkOutput("busy_in_run", 128'(bus.busy), 128'(1));
          if (bus.key_ready) begin
            checkOutput("sb_has_entry", 128'(sb.size() > 0), 128'(1));
            if (sb.size() > 0) begin
              b = sb.pop_front();
              checkOutput("beat_key", bus.key_out, b.key);
              checkOutput("beat_idx", 128'(bus.key_idx), 128'(b.idx));
              if (full_rate)
                checkOutput("beat_cycle", 128'(cyc), 128'(start_cyc + 10 - int'(b.idx)));
            end
            obs_key[bus.key_idx] = bus.key_out;
            if (bus.key_idx == 4'd0) done_due = 1'b1;
          end else begin
            prev_stall = 1'b1;
            prev_key   = bus.key_out;
            prev_idx   = bus.key_idx;
          end
        end
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_key_out"},   bus.key_out,            128'(0));
    checkOutput({tag, "_key_valid"}, 128'(bus.key_valid),    128'(0));
    checkOutput({tag, "_key_idx"},   128'(bus.key_idx),      128'(0));
    checkOutput({tag, "_busy"},      128'(bus.busy),         128'(0));
    checkOutput({tag, "_done"},      128'(bus.done),         128'(0));
  endtask

  initial begin
    int   done_cyc;
    int   pulses_before;
    bit   injected;
    bit   seen;
    bit   found;
    logic [127:0] ck;

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.key_last  = '0;
    bus.key_ready = 1'b0;
    buildSbox();

    vecs[0] = '{A1_LAST, A1_CIPHER,
                128'hac7766f319fadc2128d12941575c006e, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[1] = '{128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0,
                128'hb1d4d8e28a7db9da1d7bb3de4c664941, 128'h62636363626363636263636362636363};
    vecs[2] = '{128'h13111d7fe3944a17f307a78b4d2b30c5, 128'h000102030405060708090a0b0c0d0e0f,
                128'h549932d1f08557681093ed9cbe2c974e, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe};

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known vectors back to back: each start lands in the previous done cycle.
    full_rate = 1'b1;
    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v].key_last, vecs[v].cipher);
      runUntilDone(1'b0, done_cyc);
      checkOutput("done_latency", 128'(done_cyc), 128'(start_cyc + 11));
      checkOutput("vec_idx9", obs_key[9], vecs[v].exp9);
      checkOutput("vec_idx1", obs_key[1], vecs[v].exp1);
      checkOutput("vec_idx0", obs_key[0], vecs[v].cipher);
    end

    // Random backpressure on the A.1 vector.
    full_rate = 1'b0;
    applyStimulus(A1_LAST, A1_CIPHER);
    runUntilDone(1'b1, done_cyc);
    checkOutput("bp_idx0", obs_key[0], A1_CIPHER);
    checkOutput("bp_key_hold", bus.key_out, A1_CIPHER);

    // Start pulsed mid-run with a different key must be ignored.
    repeat (2) @(posedge clk);
    #1;
    pulses_before = done_pulses;
    full_rate     = 1'b1;
    injected      = 1'b0;
    seen          = 1'b0;
    applyStimulus(A1_LAST, A1_CIPHER);
    bus.key_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (!injected && bus.key_valid && bus.key_idx == 4'd6) begin
        bus.start    = 1'b1;
        bus.key_last = vecs[2].key_last;
        injected     = 1'b1;
      end
    end
    bus.start = 1'b0;
    checkOutput("inject_done_seen", 128'(seen), 128'(1));
    checkOutput("inject_applied", 128'(injected), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_restart", 128'(bus.key_valid), 128'(0));
    checkOutput("single_done", 128'(done_pulses - pulses_before), 128'(1));
    checkOutput("inject_sb_drained", 128'(sb.size()), 128'(0));
    checkOutput("inject_idx0", obs_key[0], A1_CIPHER);

    // Reset while idx 5 is on the bus, then a clean rerun.
    full_rate     = 1'b0;
    bus.key_ready = 1'b1;
    found         = 1'b0;
    applyStimulus(A1_LAST, A1_CIPHER);
    for (int i = 0; i < 20; i++) begin
      if (bus.key_valid && bus.key_idx == 4'd5) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("idx5_reached", 128'(found), 128'(1));
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("abort");
    rst = 1'b0;
    sb.delete();
    pulses_before = done_pulses;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 128'(done_pulses - pulses_before), 128'(0));
    checkOutput("abort_idle", 128'(bus.busy), 128'(0));
    full_rate = 1'b1;
    applyStimulus(A1_LAST, A1_CIPHER);
    runUntilDone(1'b0, done_cyc);
    checkOutput("rerun_latency", 128'(done_cyc), 128'(start_cyc + 11));
    checkOutput("rerun_idx9", obs_key[9], vecs[0].exp9);
    checkOutput("rerun_idx0", obs_key[0], A1_CIPHER);

    // Round trip of random cipher keys through the forward model.
    for (int n = 0; n < 100; n++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expandForward(ck);
      full_rate = (n % 2 == 0);
      applyStimulus(fwd_rk[10], ck);
      runUntilDone(n % 2 == 1, done_cyc);
      if (n % 2 == 0) checkOutput("rt_latency", 128'(done_cyc), 128'(start_cyc + 11));
      checkOutput("rt_idx0", obs_key[0], ck);
    end

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
